// File: rtl/link_read_queue.sv
// link_read_queue: in-order read request queue between requester and responder.
// Optional zero-latency bypass when empty; sticky flag for stray completions.
module link_read_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_read_do,
  output logic                         req_read_ready,
  input  logic [LEN_W-1:0]             req_read_length,
  input  logic                         req_read_cache_disable,
  input  logic [ADDR_W-1:0]            req_read_address,
  output logic                         req_read_done,
  output logic [DATA_W-1:0]            req_read_data,
  input  logic                         flush,
  output logic                         resp_read_do,
  output logic [LEN_W-1:0]             resp_read_length,
  output logic                         resp_read_cache_disable,
  output logic [ADDR_W-1:0]            resp_read_address,
  input  logic                         resp_read_done,
  input  logic [DATA_W-1:0]            resp_read_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_spurious_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic              mem_cd   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic empty;
  logic byp;
  logic push;
  logic pop;

  assign empty = (cnt == '0);
  assign byp   = (BYPASS != 0) && empty;

  assign count          = cnt;
  assign req_read_ready = (cnt < CW'(DEPTH));

  assign resp_read_do = empty ? (byp & req_read_do) : 1'b1;

  assign resp_read_address       = byp ? req_read_address
                                       : mem_addr[rd_ptr];
  assign resp_read_length        = byp ? req_read_length
                                       : mem_len[rd_ptr];
  assign resp_read_cache_disable = byp ? req_read_cache_disable
                                       : mem_cd[rd_ptr];

  assign req_read_done = resp_read_done & resp_read_do;
  assign req_read_data = resp_read_data;

  // A request served straight through the bypass is never stored.
  assign push = req_read_do & req_read_ready & ~flush
              & ~(byp & resp_read_done);
  assign pop  = resp_read_done & ~empty;

  // Pointers and occupancy; flush empties the queue on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: cnt <= cnt + 1'b1;
        pop & ~push: cnt <= cnt - 1'b1;
        default:     cnt <= cnt;
      endcase
    end
  end

  // Entry storage, written at the tail on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_len[i]  <= '0;
        mem_cd[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_addr[wr_ptr] <= req_read_address;
      mem_len[wr_ptr]  <= req_read_length;
      mem_cd[wr_ptr]   <= req_read_cache_disable;
    end
  end

  // Completion with nothing presented is flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_spurious_done <= 1'b0;
    else if (resp_read_done & ~resp_read_do)
      err_spurious_done <= 1'b1;
  end

endmodule
